reg_window_ctrl: RTL and testbench

- Multicycle sequencer for the 16-bit windowed-register datapath.
- Fetches instructions over a shared req/ack memory port and decodes them.
- Drives the 8x16 windowed register file (2-bit register indices, 2-bit window select, set-window strobe, write enable), the ALU op and write-data mux, and data memory accesses.
- Sits between the instruction/data memory and the register-file/ALU datapath.

---
 rtl/reg_window_ctrl.sv | 176 +++++++++++++++++
 tb/tb_reg_window_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_window_ctrl.sv
// reg_window_ctrl: multicycle fetch/decode/execute sequencer for the 16-bit windowed-register datapath.
// Build option ILLEGAL_TRAP_EN: opcodes C/D/E trap to HALT and raise a sticky illegal_op flag.
module reg_window_ctrl #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        rf_ri,
  output logic [1:0]        rf_rj,
  output logic [1:0]        rf_wnd,
  output logic              rf_set_window,
  output logic              rf_we,
  output logic [1:0]        rf_wsel,
  input  logic [15:0]       rf_data_i,
  input  logic [15:0]       rf_data_j,
  output logic [1:0]        alu_op,
  output logic [15:0]       imm_out,
  output logic [15:0]       ld_data,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal_op
);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_MOV   = 4'h5;
  localparam logic [3:0] OP_LDI   = 4'h6;
  localparam logic [3:0] OP_LOAD  = 4'h7;
  localparam logic [3:0] OP_STORE = 4'h8;
  localparam logic [3:0] OP_WIN   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_BZ    = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  logic [2:0]        r_state;
  logic [15:0]       r_ir;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_window;
  logic [15:0]       r_ld_data;
  logic [3:0]        w_op;
  logic              w_trap;
  logic              w_win_exec;
  logic [ADDR_W-1:0] w_jmp_pc;
  logic [ADDR_W-1:0] w_bz_pc;

  assign w_op     = r_ir[15:12];
  assign imm_out  = {{8{r_ir[7]}}, r_ir[7:0]};
  assign w_jmp_pc = ADDR_W'(r_ir[11:0]);
  assign w_bz_pc  = r_pc + ADDR_W'($signed(imm_out));

`ifdef ILLEGAL_TRAP_EN
  logic w_illegal;
  logic r_illegal;

  assign w_illegal = (w_op == 4'hC) || (w_op == 4'hD) || (w_op == 4'hE);
  assign w_trap    = w_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if ((r_state == S_EXEC) && w_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal_op = r_illegal;
`else
  assign w_trap     = 1'b0;
  assign illegal_op = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_INIT;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_window  <= '0;
      r_ld_data <= '0;
    end else begin
      case (r_state)
        S_INIT:   r_state <= S_FETCH;
        S_FETCH: begin
          if (mem_ack) begin
            r_ir    <= mem_rdata;
            r_pc    <= r_pc + ADDR_W'(1);
            r_state <= S_DECODE;
          end
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_LDI: r_state <= S_WB;
            OP_LOAD, OP_STORE: r_state <= S_MEM;
            OP_WIN: begin
              r_window <= r_ir[1:0];
              r_state  <= S_FETCH;
            end
            OP_JMP: begin
              r_pc    <= w_jmp_pc;
              r_state <= S_FETCH;
            end
            OP_BZ: begin
              if (rf_data_i == 16'h0000) r_pc <= w_bz_pc;
              r_state <= S_FETCH;
            end
            OP_HALT: r_state <= S_HALT;
            default: r_state <= w_trap ? S_HALT : S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            if (w_op == OP_LOAD) begin
              r_ld_data <= mem_rdata;
              r_state   <= S_WB;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_WB:    r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign mem_req   = (r_state == S_FETCH) || (r_state == S_MEM);
  assign mem_we    = (r_state == S_MEM) && (w_op == OP_STORE);
  assign mem_addr  = (r_state == S_MEM) ? ADDR_W'(rf_data_j) : r_pc;
  assign mem_wdata = rf_data_i;

  assign rf_ri = r_ir[11:10];
  assign rf_rj = r_ir[9:8];
  assign rf_we = (r_state == S_WB);

  // The new window is presented alongside its load strobe so the register file captures it in EXEC.
  assign w_win_exec    = (r_state == S_EXEC) && (w_op == OP_WIN);
  assign rf_set_window = ((r_state == S_INIT) && !rst) || w_win_exec;
  assign rf_wnd        = w_win_exec ? r_ir[1:0] : r_window;

  always_comb begin
    rf_wsel = 2'b00;
    alu_op  = 2'b00;
    case (w_op)
      OP_SUB:  alu_op  = 2'b01;
      OP_AND:  alu_op  = 2'b10;
      OP_OR:   alu_op  = 2'b11;
      OP_LDI:  rf_wsel = 2'b01;
      OP_LOAD: rf_wsel = 2'b10;
      OP_MOV:  rf_wsel = 2'b11;
      default: ;
    endcase
  end

  assign ld_data = r_ld_data;
  assign pc      = r_pc;
  assign halted  = (r_state == S_HALT);

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Bench for reg_window_ctrl: plays memory and register-file read ports, and compares every cycle
// against an instruction-level model of the controller plus a few literal expectations.
module tb_reg_window_ctrl;
  localparam int          ADDR_W   = 12;
  localparam logic [11:0] RESET_PC = 12'h000;

  localparam int P_RST = 0, P_INIT = 1, P_FETCH = 2, P_DEC = 3, P_EXEC = 4, P_MEM = 5, P_WB = 6, P_HALT = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ack;
  logic [11:0] mem_addr, pc;
  logic [15:0] mem_wdata, mem_rdata, rf_data_i, rf_data_j, imm_out, ld_data;
  logic [1:0]  rf_ri, rf_rj, rf_wnd, rf_wsel, alu_op;
  logic        rf_set_window, rf_we, halted, illegal_op;

  reg_window_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rf_ri(rf_ri), .rf_rj(rf_rj), .rf_wnd(rf_wnd), .rf_set_window(rf_set_window),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_data_i(rf_data_i), .rf_data_j(rf_data_j),
    .alu_op(alu_op), .imm_out(imm_out), .ld_data(ld_data), .pc(pc),
    .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // architectural model
  logic [11:0] m_pc;
  logic [15:0] m_ir, m_ld, m_rfi, m_rfj;
  logic [1:0]  m_win;
  logic        m_ill;
  int          phase = P_RST;
  bit          e_chk = 1'b0;

  // snapshots and counters for literal expectations
  int          c_freq, c_we;
  logic        s_init_setw, s_ex_setw, s_wb_we, s_mem_we;
  logic [1:0]  s_init_wnd, s_ex_wnd, s_wb_ri, s_wb_wsel, s_wb_alu;
  logic [15:0] s_wb_imm;
  logic [11:0] s_mem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [1:0] exp_wsel(input logic [3:0] op);
    case (op)
      4'h6:    return 2'b01;
      4'h7:    return 2'b10;
      4'h5:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] exp_alu(input logic [3:0] op);
    case (op)
      4'h2:    return 2'b01;
      4'h3:    return 2'b10;
      4'h4:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  always @(negedge clk) begin : cmp
    logic [3:0] op;
    bit         req, win_ex;
    if (e_chk) begin
      op     = m_ir[15:12];
      req    = (phase == P_FETCH) || (phase == P_MEM);
      win_ex = (phase == P_EXEC) && (op == 4'h9);
      chk("mem_req", mem_req, req);
      if (req) begin
        chk("mem_addr", mem_addr, (phase == P_FETCH) ? 32'(m_pc) : 32'(m_rfj[11:0]));
        chk("mem_we", mem_we, (phase == P_MEM) && (op == 4'h8));
      end
      if ((phase == P_MEM) && (op == 4'h8)) chk("mem_wdata", mem_wdata, m_rfi);
      chk("rf_ri", rf_ri, m_ir[11:10]);
      chk("rf_rj", rf_rj, m_ir[9:8]);
      chk("rf_wsel", rf_wsel, exp_wsel(op));
      chk("alu_op", alu_op, exp_alu(op));
      chk("imm_out", imm_out, {{8{m_ir[7]}}, m_ir[7:0]});
      chk("rf_wnd", rf_wnd, win_ex ? m_ir[1:0] : m_win);
      chk("rf_set_window", rf_set_window, (phase == P_INIT) || win_ex);
      chk("rf_we", rf_we, phase == P_WB);
      chk("we_setw_excl", rf_we & rf_set_window, 1'b0);
      chk("ld_data", ld_data, m_ld);
      chk("pc", pc, m_pc);
      chk("halted", halted, phase == P_HALT);
      chk("illegal_op", illegal_op, m_ill);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    if (rf_we) c_we++;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ack = 1'b0; phase = P_RST; e_chk = 1'b1;
    m_pc = RESET_PC; m_ir = '0; m_win = '0; m_ld = '0; m_ill = 1'b0;
    #1;
    chk("rst_req_low", mem_req, 1'b0);
    chk("rst_we_low", mem_we, 1'b0);
    step();
    step();
    rst = 1'b0; phase = P_INIT;
    #1;
    s_init_setw = rf_set_window;
    s_init_wnd  = rf_wnd;
    step();
    phase = P_FETCH;
  endtask

  task automatic do_wb();
    phase = P_WB;
    s_wb_we = rf_we; s_wb_ri = rf_ri; s_wb_wsel = rf_wsel; s_wb_alu = alu_op; s_wb_imm = imm_out;
    mem_ack = 1'($urandom_range(0, 1));
    tick();
    mem_ack = 1'b0;
  endtask

  // Executes one instruction from the FETCH cycle until the controller is back in FETCH (or HALT).
  task automatic run_instr(input logic [15:0] instr, input logic [15:0] rfi, input logic [15:0] rfj,
                           input logic [15:0] rdata, input int fd, input int md, input bit rst_in_mem);
    logic [3:0] op;
    bit         to_halt;
    op = instr[15:12];
    to_halt = 1'b0;
    c_freq = 0; c_we = 0;
    m_rfi = rfi; m_rfj = rfj; rf_data_i = rfi; rf_data_j = rfj;
    phase = P_FETCH;
    for (int k = 0; k < fd; k++) begin
      mem_ack = 1'b0; mem_rdata = 16'($urandom);
      if (mem_req) c_freq++;
      tick();
    end
    mem_ack = 1'b1; mem_rdata = instr;
    if (mem_req) c_freq++;
    tick();
    m_ir = instr; m_pc = m_pc + 12'd1;
    phase = P_DEC; mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
    tick();
    phase = P_EXEC; mem_ack = 1'($urandom_range(0, 1));
    s_ex_setw = rf_set_window; s_ex_wnd = rf_wnd;
    tick();
    mem_ack = 1'b0;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: do_wb();
      4'h7, 4'h8: begin
        phase = P_MEM;
        if (rst_in_mem) begin
          #2;
          chk("mem_req_in_mem", mem_req, 1'b1);
          do_reset();
          return;
        end
        s_mem_addr = mem_addr; s_mem_we = mem_we;
        for (int k = 0; k < md; k++) begin
          mem_ack = 1'b0; mem_rdata = 16'($urandom);
          tick();
        end
        mem_ack = 1'b1; mem_rdata = rdata;
        tick();
        mem_ack = 1'b0;
        if (op == 4'h7) begin
          m_ld = rdata;
          do_wb();
        end
      end
      4'h9: m_win = instr[1:0];
      4'hA: m_pc = instr[11:0];
      4'hB: if (rfi == 16'h0) m_pc = m_pc + {{4{instr[7]}}, instr[7:0]};
      4'hF: to_halt = 1'b1;
      4'hC, 4'hD, 4'hE: begin
`ifdef ILLEGAL_TRAP_EN
        m_ill = 1'b1;
        to_halt = 1'b1;
`endif
      end
      default: ;
    endcase
    phase = to_halt ? P_HALT : P_FETCH;
  endtask

  initial begin
    logic [15:0] instr, rfi;
    mem_ack = 1'b0; mem_rdata = '0; rf_data_i = '0; rf_data_j = '0;
    #2;
    do_reset();
    chk("lit_init_setw", s_init_setw, 1'b1);
    chk("lit_init_wnd", s_init_wnd, 2'd0);

    run_instr(16'h6405, 16'h0, 16'h0, 16'h0, 0, 0, 1'b0);
    chk("lit_ldi_we", s_wb_we, 1'b1);
    chk("lit_ldi_ri", s_wb_ri, 2'd1);
    chk("lit_ldi_wsel", s_wb_wsel, 2'b01);
    chk("lit_ldi_imm", s_wb_imm, 16'h0005);
    chk("lit_ldi_pc", pc, 12'h001);

    run_instr(16'h1100, 16'h1234, 16'h0101, 16'h0, 3, 0, 1'b0);
    chk("lit_add_req_cycles", c_freq, 4);
    chk("lit_add_we_cycles", c_we, 1);
    chk("lit_add_alu", s_wb_alu, 2'b00);
    chk("lit_add_wsel", s_wb_wsel, 2'b00);

    run_instr(16'h9003, 16'h0, 16'h0, 16'h0, 1, 0, 1'b0);
    chk("lit_win_setw", s_ex_setw, 1'b1);
    chk("lit_win_wnd", s_ex_wnd, 2'd3);
    chk("lit_win_no_we", c_we, 0);

    run_instr(16'h7100, 16'h0, 16'h0020, 16'hBEEF, 0, 2, 1'b0);
    chk("lit_load_addr", s_mem_addr, 12'h020);
    chk("lit_load_we", s_mem_we, 1'b0);
    chk("lit_load_data", ld_data, 16'hBEEF);
    chk("lit_load_wsel", s_wb_wsel, 2'b10);

    run_instr(16'hA010, 16'h0, 16'h0, 16'h0, 0, 0, 1'b0);
    chk("lit_jmp_pc", pc, 12'h010);
    run_instr(16'hB0FE, 16'h0000, 16'h0, 16'h0, 1, 0, 1'b0);
    chk("lit_bz_taken_pc", pc, 12'h00F);
    run_instr(16'hA010, 16'h0, 16'h0, 16'h0, 0, 0, 1'b0);
    run_instr(16'hB0FE, 16'h0001, 16'h0, 16'h0, 0, 0, 1'b0);
    chk("lit_bz_not_taken_pc", pc, 12'h011);

    run_instr(16'hC000, 16'h0, 16'h0, 16'h0, 0, 0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    chk("lit_trap_halted", halted, 1'b1);
    chk("lit_trap_illegal", illegal_op, 1'b1);
    for (int k = 0; k < 4; k++) begin
      mem_ack = 1'($urandom_range(0, 1));
      tick();
    end
    mem_ack = 1'b0;
`else
    chk("lit_illegal_nop_pc", pc, 12'h012);
    chk("lit_illegal_next_fetch", mem_addr, 12'h012);
`endif

    do_reset();
    for (int n = 0; n < 200; n++) begin
      instr = {4'($urandom_range(0, 11)), 12'($urandom)};
      rfi   = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
      run_instr(instr, rfi, 16'($urandom), 16'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    run_instr(16'hF000, 16'h0, 16'h0, 16'h0, 1, 0, 1'b0);
    chk("lit_halt_halted", halted, 1'b1);
    for (int k = 0; k < 5; k++) begin
      mem_ack = 1'($urandom_range(0, 1));
      tick();
    end
    mem_ack = 1'b0;

    do_reset();
    run_instr(16'h6401, 16'h0, 16'h0, 16'h0, 0, 0, 1'b0);
    run_instr(16'h8100, 16'h5A5A, 16'h0033, 16'h0, 0, 0, 1'b1);
    chk("lit_restart_req", mem_req, 1'b1);
    chk("lit_restart_addr", mem_addr, 12'h000);
    chk("lit_restart_pc", pc, 12'h000);
    run_instr(16'h6A7F, 16'h0, 16'h0, 16'h0, 1, 0, 1'b0);
    chk("lit_after_restart_pc", pc, 12'h001);
    chk("lit_after_restart_imm", s_wb_imm, 16'h007F);

    e_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
